// File: rtl/lcd_char_writer.sv
`timescale 1ns/1ps
// lcd_char_writer: HD44780-style character writer. It runs a power-on wait and
// an init command sequence. After that it accepts single characters or clear
// requests. Every LCD transfer has three phases: SETUP, PULSE and HOLD.
module lcd_char_writer #(
  parameter int unsigned TICK_DIV  = 50,
  parameter int unsigned PWR_TICKS = 1000,
  parameter int unsigned CLR_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_char,
  input  logic       i_valid,
  input  logic       i_clear,
  output logic       o_ready,
  output logic [3:0] o_col,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PMAX0 = (PWR_TICKS > CLR_TICKS) ? PWR_TICKS : CLR_TICKS;
  localparam int unsigned PMAX  = (PMAX0 > 3) ? PMAX0 : 3;
  localparam int unsigned PW    = $clog2(PMAX);

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_FS,
    INIT_DISP,
    INIT_ENTRY,
    INIT_CLR,
    CLR_WAIT,
    IDLE,
    WR_CHAR,
    WR_HOME,
    WR_CLR
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [3:0]      col_q, col_d;
  logic [7:0]      char_q, char_d;

  logic            phase_end;
  logic            last_phase;
  logic            xfer;
  logic [PW-1:0]   ph_limit;

  // State, phase counters, cursor column and captured character
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PWR_WAIT;
      tick_q  <= '0;
      ph_q    <= '0;
      col_q   <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      ph_q    <= ph_d;
      col_q   <= col_d;
      char_q  <= char_d;
    end
  end

  // Phase length per state and end-of-state detection
  always_comb begin
    xfer = (state_q == INIT_FS) || (state_q == INIT_DISP) ||
           (state_q == INIT_ENTRY) || (state_q == INIT_CLR) ||
           (state_q == WR_CHAR) || (state_q == WR_HOME) || (state_q == WR_CLR);
    case (state_q)
      PWR_WAIT: ph_limit = PW'(PWR_TICKS - 1);
      CLR_WAIT: ph_limit = PW'(CLR_TICKS - 1);
      default:  ph_limit = PW'(2);
    endcase
    phase_end  = (tick_q == TW'(TICK_DIV - 1));
    last_phase = phase_end && (ph_q == ph_limit);
  end

  // Next-state logic: IDLE holds the counters at zero, so each transfer
  // starts with a full SETUP phase
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    ph_d    = ph_q;
    col_d   = col_q;
    char_d  = char_q;
    if (state_q == IDLE) begin
      tick_d = '0;
      ph_d   = '0;
      if (i_clear) begin
        state_d = WR_CLR;
        col_d   = '0;
      end else if (i_valid) begin
        state_d = WR_CHAR;
        char_d  = i_char;
      end
    end else begin
      tick_d = phase_end ? '0 : tick_q + TW'(1);
      if (phase_end) begin
        ph_d = last_phase ? '0 : ph_q + PW'(1);
      end
      if (last_phase) begin
        case (state_q)
          PWR_WAIT:   state_d = INIT_FS;
          INIT_FS:    state_d = INIT_DISP;
          INIT_DISP:  state_d = INIT_ENTRY;
          INIT_ENTRY: state_d = INIT_CLR;
          INIT_CLR:   state_d = CLR_WAIT;
          CLR_WAIT:   state_d = IDLE;
          WR_CLR:     state_d = CLR_WAIT;
          WR_HOME:    state_d = IDLE;
          WR_CHAR: begin
            if (col_q == 4'd15) begin
              col_d   = '0;
              state_d = WR_HOME;
            end else begin
              col_d   = col_q + 4'd1;
              state_d = IDLE;
            end
          end
          default:    state_d = PWR_WAIT;
        endcase
      end
    end
  end

  // LCD bus decode: rs/data fixed per state, so they stay stable for the
  // whole transfer; enable only in the PULSE phase
  always_comb begin
    lcd_rs   = 1'b0;
    lcd_data = '0;
    case (state_q)
      INIT_FS:    lcd_data = 8'h38;
      INIT_DISP:  lcd_data = 8'h0C;
      INIT_ENTRY: lcd_data = 8'h06;
      INIT_CLR:   lcd_data = 8'h01;
      WR_CLR:     lcd_data = 8'h01;
      WR_HOME:    lcd_data = 8'h80;
      WR_CHAR: begin
        lcd_rs   = 1'b1;
        lcd_data = char_q;
      end
      default: begin
        lcd_rs   = 1'b0;
        lcd_data = '0;
      end
    endcase
    lcd_e = xfer && (ph_q == PW'(1));
  end

  assign o_ready = (state_q == IDLE);
  assign o_col   = col_q;
  assign lcd_rw  = 1'b0;

endmodule

// File: tb/tb_lcd_char_writer.sv
`timescale 1ns/1ps
module tb_lcd_char_writer;

  localparam int unsigned TD = 2;
  localparam int unsigned PT = 4;
  localparam int unsigned CT = 3;
  localparam int XFER_CLK = 3 * TD;
  localparam int INIT_CLK = PT * TD + 4 * XFER_CLK + CT * TD;
  localparam int CLR_CLK  = XFER_CLK + CT * TD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_char = '0;
  logic       i_valid = 1'b0;
  logic       i_clear = 1'b0;
  logic       o_ready;
  logic [3:0] o_col;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_char_writer #(.TICK_DIV(TD), .PWR_TICKS(PT), .CLR_TICKS(CT)) dut (
    .clk(clk), .rst(rst), .i_char(i_char), .i_valid(i_valid), .i_clear(i_clear),
    .o_ready(o_ready), .o_col(o_col), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  int total = 0;
  int bad = 0;

  // Reference model: queue of expected bus transfers {rs,data}, clocks left
  // until the block is idle again, and the cursor column
  logic [8:0] expq[$];
  int m_busy = INIT_CLK;
  int m_col = 0;
  int m_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    expq.delete();
    expq.push_back(9'h038);
    expq.push_back(9'h00C);
    expq.push_back(9'h006);
    expq.push_back(9'h001);
    m_busy = INIT_CLK;
    m_col  = 0;
  endfunction

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 2))
      0: return 8'h20;
      1: return 8'h30 + 8'($urandom_range(0, 9));
      default: return 8'($urandom);
    endcase
  endfunction

  // One clock: drive inputs, advance the model at the edge, check at negedge
  task automatic step(input logic v, input logic c, input logic [7:0] ch);
    i_valid = v;
    i_clear = c;
    i_char  = ch;
    @(posedge clk);
    if (m_busy == 0) begin
      if (c) begin
        expq.push_back(9'h001);
        m_col  = 0;
        m_busy = CLR_CLK;
      end else if (v) begin
        m_acc++;
        expq.push_back({1'b1, ch});
        if (m_col == 15) begin
          expq.push_back(9'h080);
          m_col  = 0;
          m_busy = 2 * XFER_CLK;
        end else begin
          m_col++;
          m_busy = XFER_CLK;
        end
      end
    end else begin
      m_busy--;
    end
    @(negedge clk);
    chk("ready", o_ready, (m_busy == 0));
    chk("rw", lcd_rw, 0);
    if (m_busy == 0) chk("col", o_col, m_col);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 200) begin
      step(1'b0, 1'b0, rand_char());
      n++;
    end
    chk("ready_wait", o_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_valid = 1'b0;
    i_clear = 1'b0;
    #1;
    chk("rst_e", lcd_e, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_col", o_col, 0);
    expq.delete();
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic check_init_latency();
    int n = 0;
    while (!o_ready && n < 100) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk("pwr_lat", n, INIT_CLK);
  endtask

  // Bus monitor: each enable pulse must carry the next expected transfer
  // and last exactly TD clocks
  int   hcnt = 0;
  logic e_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      e_prev <= 1'b0;
      hcnt   <= 0;
    end else begin
      e_prev <= lcd_e;
      if (lcd_e) hcnt <= hcnt + 1;
      if (lcd_e && !e_prev) begin
        chk("xfer_pending", (expq.size() > 0), 1);
        if (expq.size() > 0) chk("xfer_rise", {lcd_rs, lcd_data}, expq[0]);
      end
      if (!lcd_e && e_prev) begin
        chk("e_width", hcnt, TD);
        if (expq.size() > 0) chk("xfer_hold", {lcd_rs, lcd_data}, expq.pop_front());
        hcnt <= 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();
    check_init_latency();

    // single character
    wait_ready();
    step(1'b1, 1'b0, 8'h35);
    n = 0;
    while (!o_ready && n < 50) begin
      step(1'b0, 1'b0, rand_char());
      n++;
    end
    chk("char_busy", n, XFER_CLK);
    chk("col_one", o_col, 1);

    // clear and valid together: clear wins
    step(1'b1, 1'b1, 8'h37);
    n = 0;
    while (!o_ready && n < 50) begin
      step(1'b1, 1'b0, 8'h41);
      n = n + 1;
      if (n == 1) begin
        i_valid = 1'b0;
      end
    end
    chk("clr_busy", n, CLR_CLK);
    chk("col_clr", o_col, 0);

    // 16 back-to-back characters wrap the line and send home
    m_acc = 0;
    n = 0;
    while (m_acc < 16 && n < 400) begin
      step(1'b1, 1'b0, 8'h30 + 8'(n % 10));
      n++;
    end
    chk("acc16", m_acc, 16);
    wait_ready();
    chk("col_wrap", o_col, 0);

    // valid held for 20 clocks with a changing character
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, rand_char());
    wait_ready();

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), rand_char());
    wait_ready();

    // reset in the middle of an enable pulse
    step(1'b1, 1'b0, 8'h39);
    n = 0;
    while (!lcd_e && n < 20) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk("pulse_seen", lcd_e, 1);
    #2;
    do_reset();
    check_init_latency();
    for (int i = 0; i < 100; i++)
      step(($urandom_range(0, 1) != 0), ($urandom_range(0, 19) == 0), rand_char());
    wait_ready();
    repeat (4) step(1'b0, 1'b0, 8'h00);
    chk("queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
